// File: rtl/mem_responder_pkg.sv
// Shared constants and address decode for the mem_responder CPU-bus slave.
package mem_responder_pkg;

  localparam logic [27:0] IO_PAGE       = 28'hFFFFFFF;
  localparam logic [31:0] CON_TX_ADDR   = 32'hFFFF_FFF0;
  localparam logic [31:0] CON_STAT_ADDR = 32'hFFFF_FFF4;

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_OVF   = 2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_CON_TX,
    SEL_CON_STAT,
    SEL_IO_OTHER
  } sel_e;

  // Classify a CPU word address when the I/O page is decoded.
  function automatic sel_e decode_addr(input logic [31:0] addr);
    if (addr[31:4] != IO_PAGE) return SEL_RAM;
    if (addr == CON_TX_ADDR)   return SEL_CON_TX;
    if (addr == CON_STAT_ADDR) return SEL_CON_STAT;
    return SEL_IO_OTHER;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus plus console sink handshake seen by mem_responder.
interface mem_responder_if;
  logic [31:0] address;
  logic        rw;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  modport master (
    output address, rw, wdata, con_ready,
    input  rdata, con_data, con_valid
  );

  modport slave (
    input  address, rw, wdata, con_ready,
    output rdata, con_data, con_valid
  );
endinterface

// File: rtl/mem_responder_console_fifo.sv
// console_fifo: byte FIFO for the memory-mapped console.
// Head byte is forced to 0 while empty so reset withdraws it at once.
module console_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  logic [7:0]          slot_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                push_ok, pop_ok;

  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign empty   = (count_q == '0);
  // A same-edge pop frees the slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : slot_q[rd_ptr_q];

  // Next pointer/count values from accepted push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_BITS'(push_ok) - CNT_BITS'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer and count state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because dout is gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM with optional memory-mapped console.
// Console (I/O page decode, FIFO, CON_STAT) is built only when
// MEM_RESPONDER_CONSOLE_EN is defined; otherwise every address aliases RAM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic             clock,
  input logic             reset,
  mem_responder_if.slave  bus
);

  logic [31:0]          mem [0:(1 << ADDR_BITS) - 1];
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          stat_word;
  logic                 is_read, is_write;
  sel_e                 sel;

  assign idx       = bus.address[ADDR_BITS-1:0];
  assign is_read   = (bus.rw == RW_READ);
  assign is_write  = (bus.rw == RW_WRITE);
  assign bus.rdata = rdata_q;

`ifdef MEM_RESPONDER_CONSOLE_EN
  logic       push, pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       overflow_q, overflow_d;

  assign sel  = decode_addr(bus.address);
  assign push = is_write && (sel == SEL_CON_TX);
  assign pop  = !fifo_empty && bus.con_ready;

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_console_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .din   (bus.wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.con_valid = !fifo_empty;
  assign bus.con_data  = fifo_dout;

  // Status word reflects FIFO state before this edge's push/pop.
  always_comb begin
    stat_word           = '0;
    stat_word[STAT_EMPTY] = fifo_empty;
    stat_word[STAT_FULL]  = fifo_full;
    stat_word[STAT_OVF]   = overflow_q;
  end

  // Sticky overflow: set by a dropped push, cleared by writing bit 2 of CON_STAT.
  always_comb begin
    overflow_d = overflow_q;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    if (is_write && (sel == SEL_CON_STAT) && bus.wdata[STAT_OVF]) overflow_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end
`else
  logic unused_inputs;

  assign sel           = SEL_RAM;
  assign stat_word     = '0;
  assign bus.con_valid = 1'b0;
  assign bus.con_data  = '0;
  assign unused_inputs = ^{bus.address[31:ADDR_BITS], bus.con_ready};
`endif

  // Read data mux; writes leave rdata unchanged.
  always_comb begin
    rdata_d = rdata_q;
    if (is_read) begin
      case (sel)
        SEL_RAM:      rdata_d = mem[idx];
        SEL_CON_STAT: rdata_d = stat_word;
        default:      rdata_d = '0;
      endcase
    end
  end

  // Read data register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  // RAM write port; contents are not reset.
  always_ff @(posedge clock) begin
    if (is_write && (sel == SEL_RAM)) mem[idx] <= bus.wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder; console section runs when
// MEM_RESPONDER_CONSOLE_EN is defined.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_errors;

  mem_responder_if bus ();

  mem_responder #(.ADDR_BITS(10), .FIFO_DEPTH(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.rw      = RW_WRITE;
    bus.address = addr;
    bus.wdata   = data;
    tick();
    bus.rw      = RW_READ;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    bus.rw      = RW_READ;
    bus.address = addr;
    tick();
  endtask

`ifdef MEM_RESPONDER_CONSOLE_EN
  logic [7:0] drain_exp [8];
  logic [7:0] tog_exp [3];
  logic       tog_pat [5];
  int unsigned head;
  int unsigned handshakes;
`endif

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.rw      = RW_READ;
    bus.address = '0;
    bus.wdata   = '0;
    bus.con_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_con_valid", {31'b0, bus.con_valid}, 32'h0);
    check("reset_con_data", {24'b0, bus.con_data}, 32'h0);

    // RAM write/read, hold on write, aliasing
    bus_write(32'h5, 32'hDEAD_BEEF);
    check("write_holds_rdata", bus.rdata, 32'h0);
    bus_read(32'h5);
    check("ram_read_5", bus.rdata, 32'hDEAD_BEEF);
    bus_write(32'h7, 32'h1234_5678);
    check("write_holds_rdata2", bus.rdata, 32'hDEAD_BEEF);
    bus_read(32'h405);
    check("ram_alias_405", bus.rdata, 32'hDEAD_BEEF);
    bus_read(32'h7);
    check("ram_read_7", bus.rdata, 32'h1234_5678);

`ifdef MEM_RESPONDER_CONSOLE_EN
    bus_read(CON_STAT_ADDR);
    check("stat_after_reset", bus.rdata, 32'h1);
    bus_read(CON_TX_ADDR);
    check("con_tx_reads_zero", bus.rdata, 32'h0);
    bus_write(32'hFFFF_FFF8, 32'hAAAA_5555);
    bus_read(32'h3F8);
    check("io_other_not_ram", bus.rdata, 32'h0);

    // Fill FIFO with ready low
    bus.con_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_write(CON_TX_ADDR, 32'h41 + i);
      if (i == 0) begin
        check("valid_after_push", {31'b0, bus.con_valid}, 32'h1);
        check("data_after_push", {24'b0, bus.con_data}, 32'h41);
      end
    end
    bus_read(CON_STAT_ADDR);
    check("stat_full", bus.rdata, 32'h2);
    bus_write(CON_TX_ADDR, 32'h49);
    bus_read(CON_STAT_ADDR);
    check("stat_overflow", bus.rdata, 32'h6);
    check("head_stable_full", {24'b0, bus.con_data}, 32'h41);
    bus_write(CON_STAT_ADDR, 32'h4);
    bus_read(CON_STAT_ADDR);
    check("stat_ovf_cleared", bus.rdata, 32'h2);

    // Push and pop on the same edge while full
    check("head_before_pushpop", {24'b0, bus.con_data}, 32'h41);
    bus.con_ready = 1'b1;
    bus_write(CON_TX_ADDR, 32'h5A);
    bus.con_ready = 1'b0;
    bus_read(CON_STAT_ADDR);
    check("stat_full_no_ovf", bus.rdata, 32'h2);

    // Drain one byte per cycle
    drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};
    bus.address   = 32'h0;
    bus.con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid_%0d", i), {31'b0, bus.con_valid}, 32'h1);
      check($sformatf("drain_data_%0d", i), {24'b0, bus.con_data}, {24'b0, drain_exp[i]});
      tick();
    end
    check("drained_valid", {31'b0, bus.con_valid}, 32'h0);
    bus_read(CON_STAT_ADDR);
    check("stat_drained", bus.rdata, 32'h1);
    bus.con_ready = 1'b0;

    // Ready toggling with three queued bytes
    tog_exp = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 3; i++) bus_write(CON_TX_ADDR, 32'h61 + i);
    tog_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    head = 0;
    handshakes = 0;
    bus.address = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("tog_valid_%0d", i), {31'b0, bus.con_valid}, 32'h1);
      check($sformatf("tog_data_%0d", i), {24'b0, bus.con_data}, {24'b0, tog_exp[head]});
      bus.con_ready = tog_pat[i];
      if (bus.con_valid && bus.con_ready) handshakes++;
      tick();
      if (tog_pat[i]) head++;
    end
    bus.con_ready = 1'b0;
    check("tog_handshakes", handshakes, 32'd3);
    check("tog_valid_end", {31'b0, bus.con_valid}, 32'h0);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) bus_write(CON_TX_ADDR, 32'h71 + i);
    bus.con_ready = 1'b1;
    bus.address   = 32'h0;
    tick();
    check("pre_reset_data", {24'b0, bus.con_data}, 32'h72);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_valid", {31'b0, bus.con_valid}, 32'h0);
    check("async_reset_data", {24'b0, bus.con_data}, 32'h0);
    rst = 1'b0;
    tick();
    bus.con_ready = 1'b0;
    bus_read(CON_STAT_ADDR);
    check("stat_after_midreset", bus.rdata, 32'h1);
    bus_read(32'h5);
    check("ram_survives_reset", bus.rdata, 32'hDEAD_BEEF);
`else
    // Without the console the I/O page aliases RAM
    bus.con_ready = 1'b1;
    bus_write(32'hFFFF_FFF0, 32'hCAFE_F00D);
    bus_write(32'hFFFF_FFF4, 32'h0000_0004);
    check("no_console_valid", {31'b0, bus.con_valid}, 32'h0);
    check("no_console_data", {24'b0, bus.con_data}, 32'h0);
    bus_read(32'h3F0);
    check("io_alias_3f0", bus.rdata, 32'hCAFE_F00D);
    bus_read(32'hFFFF_FFF4);
    check("io_alias_fff4", bus.rdata, 32'h0000_0004);
    bus.con_ready = 1'b0;

    // Asynchronous reset between edges
    bus_read(32'h5);
    check("pre_reset_rdata", bus.rdata, 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    tick();
    bus_read(32'h5);
    check("ram_survives_reset", bus.rdata, 32'hDEAD_BEEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
